// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup for fetch, training from the resolved branch, mispredict counter.
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        if_predict_taken,
    output logic [31:0] if_predict_target,
    input  logic        mb_resolve,
    input  logic [31:0] mb_pc,
    input  logic        mb_branch_taken,
    input  logic [31:0] mb_jump_target,
    input  logic        mb_predict_taken,
    input  logic [31:0] mb_predict_target,
    output logic        mispredict,
    output logic [31:0] mispredict_count
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic [ENTRIES-1:0]           w_valid;
    logic [ENTRIES-1:0][TAGW-1:0] w_tag;
    logic [ENTRIES-1:0][31:0]     w_target;
    logic [ENTRIES-1:0][1:0]      w_ctr;

    logic [IDX-1:0]  w_if_idx;
    logic [TAGW-1:0] w_if_tag;
    logic            w_if_hit;
    logic [IDX-1:0]  w_mb_idx;
    logic [TAGW-1:0] w_mb_tag;
    logic            w_mb_hit;
    logic            w_mispredict;
    logic [1:0]      w_unused_mb_pc_lo;

    logic            r_mispredict;
    logic [31:0]     r_mispredict_count;

    assign w_if_idx          = if_pc[IDX+1:2];
    assign w_if_tag          = if_pc[31:IDX+2];
    assign w_mb_idx          = mb_pc[IDX+1:2];
    assign w_mb_tag          = mb_pc[31:IDX+2];
    assign w_unused_mb_pc_lo = mb_pc[1:0];

    // Lookup reads the registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        w_if_hit          = w_valid[w_if_idx] && (w_tag[w_if_idx] == w_if_tag);
        if_predict_taken  = w_if_hit && w_ctr[w_if_idx][1] && (if_pc[1:0] == 2'b00);
        if_predict_target = if_predict_taken ? w_target[w_if_idx] : 32'h0;
    end

    assign w_mb_hit = w_valid[w_mb_idx] && (w_tag[w_mb_idx] == w_mb_tag);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic            r_valid;
            logic [TAGW-1:0] r_tag;
            logic [31:0]     r_target;
            logic [1:0]      r_ctr;
            logic            w_sel;

            assign w_sel = mb_resolve && (w_mb_idx == IDX'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid  <= 1'b0;
                    r_tag    <= '0;
                    r_target <= 32'h0;
                    r_ctr    <= 2'd0;
                end else if (w_sel) begin
                    if (w_mb_hit) begin
                        if (mb_branch_taken) begin
                            if (r_ctr != 2'd3) r_ctr <= r_ctr + 2'd1;
                            r_target <= mb_jump_target;
                        end else if (r_ctr != 2'd0) begin
                            r_ctr <= r_ctr - 2'd1;
                        end
                    end else if (mb_branch_taken) begin
                        // Allocation overwrites whatever aliasing entry held this slot.
                        r_valid  <= 1'b1;
                        r_tag    <= w_mb_tag;
                        r_target <= mb_jump_target;
                        r_ctr    <= 2'd2;
                    end
                end
            end

            assign w_valid[gi]  = r_valid;
            assign w_tag[gi]    = r_tag;
            assign w_target[gi] = r_target;
            assign w_ctr[gi]    = r_ctr;
        end
    endgenerate

    assign w_mispredict = mb_resolve &&
                          ((mb_predict_taken != mb_branch_taken) ||
                           (mb_branch_taken && (mb_predict_target != mb_jump_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredict       <= 1'b0;
            r_mispredict_count <= 32'h0;
        end else begin
            r_mispredict <= w_mispredict;
            if (w_mispredict) r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

    assign mispredict       = r_mispredict;
    assign mispredict_count = r_mispredict_count;

endmodule
